ccff_chain_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the fabric's connection/switch-block configuration chain. It accepts bitstream words over a valid/ready handshake, serializes them MSB-first onto `ccff_head`, and produces a clock-enable for the external gate that drives the fabric-side `prog_clk`, so that the chain shifts only on valid bits. An optional verify pass compares the bits returning on `ccff_tail` against a resent copy of the bitstream.

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_word_serializer.sv | 79 +++++++
 rtl/ccff_chain_loader.sv | 137 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
// The VERIFY state is only reachable when CCFF_CHAIN_LOADER_VERIFY_EN is defined.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_loader_state_e;

  localparam int unsigned CCFF_CHAIN_LEN_DEF = 33;
  localparam int unsigned CCFF_WORD_W_DEF    = 8;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: one shift register backed by one buffer word, MSB first.
// Each stored word carries its own bit length so a truncated final word never shifts its tail.
module ccff_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  output logic              buf_empty,
  input  logic              shift_en,
  output logic              bit_out,
  output logic              bit_valid
);

  logic [WORD_W-1:0] sh_q, sh_d, buf_q, buf_d;
  logic [LEN_W-1:0]  sh_len_q, sh_len_d, buf_len_q, buf_len_d;
  logic              buf_full_q, buf_full_d;

  always_comb begin
    sh_d       = sh_q;
    sh_len_d   = sh_len_q;
    buf_d      = buf_q;
    buf_len_d  = buf_len_q;
    buf_full_d = buf_full_q;
    if (shift_en && (sh_len_q != '0)) begin
      sh_d     = sh_q << 1;
      sh_len_d = sh_len_q - LEN_W'(1);
    end
    // Refill on the same cycle the last bit leaves; an incoming word skips the buffer when both are empty.
    if (sh_len_d == '0) begin
      if (buf_full_q) begin
        sh_d       = buf_q;
        sh_len_d   = buf_len_q;
        buf_d      = '0;
        buf_len_d  = '0;
        buf_full_d = 1'b0;
      end else if (in_valid) begin
        sh_d     = in_data;
        sh_len_d = in_len;
      end
    end else if (in_valid) begin
      buf_d      = in_data;
      buf_len_d  = in_len;
      buf_full_d = 1'b1;
    end
    if (clear) begin
      sh_d       = '0;
      sh_len_d   = '0;
      buf_d      = '0;
      buf_len_d  = '0;
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      sh_len_q   <= '0;
      buf_q      <= '0;
      buf_len_q  <= '0;
      buf_full_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      sh_len_q   <= sh_len_d;
      buf_q      <= buf_d;
      buf_len_q  <= buf_len_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign bit_out   = sh_q[WORD_W-1];
  assign bit_valid = (sh_len_q != '0);
  assign buf_empty = !buf_full_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the fabric configuration chain MSB-first with a gated-clock enable for prog_clk.
// Optional loopback verify pass enabled by defining CCFF_CHAIN_LOADER_VERIFY_EN.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int unsigned WORD_W    = CCFF_WORD_W_DEF,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned N_WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_LEN = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int unsigned LEN_W    = $clog2(WORD_W + 1);
  localparam int unsigned WCNT_W   = $clog2(N_WORDS + 1);
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  ccff_loader_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic head_q, head_d, en_q, en_d, busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic             ser_buf_empty, ser_bit, ser_bit_valid, ser_clear;
  logic             accept, pass_end, shift_en, consume;
  logic [LEN_W-1:0] word_len;

  // Word acceptance stops after the pass's last word so the next pass's words are not swallowed.
  assign cfg_ready = busy_q && ser_buf_empty && (wcnt_q != WCNT_W'(N_WORDS));
  assign accept    = cfg_valid && cfg_ready;
  assign word_len  = (wcnt_q == WCNT_W'(N_WORDS - 1)) ? LEN_W'(LAST_LEN) : LEN_W'(WORD_W);
  assign pass_end  = busy_q && (cnt_q == CNT_W'(CHAIN_LEN));
  assign shift_en  = busy_q && !pass_end;
  assign consume   = shift_en && ser_bit_valid;
  assign ser_clear = pass_end || (start && !busy_q);

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_ser (
    .clk       (prog_clk),
    .rst       (prog_reset),
    .clear     (ser_clear),
    .in_valid  (accept),
    .in_data   (cfg_data),
    .in_len    (word_len),
    .buf_empty (ser_buf_empty),
    .shift_en  (shift_en),
    .bit_out   (ser_bit),
    .bit_valid (ser_bit_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    head_d  = consume ? ser_bit : head_q;
    en_d    = consume;
    if (consume) cnt_d = cnt_q + CNT_W'(1);
    if (accept)  wcnt_d = wcnt_q + WCNT_W'(1);
    // Tail lags head by exactly CHAIN_LEN shifts, so pass-1 bit k meets pass-2 bit k here.
    if (VERIFY_EN && (state_q == VERIFY) && en_q && (ccff_tail != head_q)) error_d = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          wcnt_d  = '0;
        end
      end
      LOAD, VERIFY: begin
        if (pass_end) begin
          cnt_d  = '0;
          wcnt_d = '0;
          if (VERIFY_EN && (state_q == LOAD)) begin
            state_d = VERIFY;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ccff_head    = head_q;
  assign chain_clk_en = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: scoreboard of expected head bits plus a chain model on ccff_tail.
// Verify-pass checks run when CCFF_CHAIN_LOADER_VERIFY_EN is defined.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 33;
  localparam int WORD_W    = 8;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic              prog_clk, prog_reset, start, cfg_valid, cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              ccff_head, chain_clk_en, ccff_tail, busy, done, error;

  ccff_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .chain_clk_en (chain_clk_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];
  logic [CHAIN_LEN-1:0] chain = '0;
  int  cyc = 0;
  int  en_count, first_en, last_en, p1_last, done_cyc;
  bit  done_seen;

  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fabric chain: shifts on the gated prog_clk edge closing an enabled cycle.
  always @(posedge prog_clk)
    if (chain_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};

  always @(negedge prog_clk) begin
    cyc++;
    if (!prog_reset) begin
      if (chain_clk_en) begin
        if (exp_q.size() == 0) check("extra_shift", 1, 0);
        else check("head_bit", ccff_head, exp_q.pop_front());
        en_count++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (en_count == CHAIN_LEN) p1_last = cyc;
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_stats();
    en_count  = 0;
    first_en  = -1;
    last_en   = -1;
    p1_last   = -1;
    done_seen = 1'b0;
    done_cyc  = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_stats();
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    bit ok = 1'b0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (cfg_ready) begin
        for (int b = 0; b < nbits; b++) exp_q.push_back(w[7-b]);
        ok = 1'b1;
        break;
      end
    end
    tick();
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic do_pass(input logic [7:0] w1, input int gap, input bit poke);
    logic [7:0] words [5];
    words = '{8'hA5, w1, 8'hFF, 8'h00, 8'h80};
    for (int i = 0; i < 5; i++) begin
      if (i == 2 && gap > 0) begin
        cfg_valid = 1'b0;
        repeat (gap) tick();
      end
      if (i == 1 && poke) begin
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_word(words[i], (i == 4) ? 1 : 8);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      @(negedge prog_clk);
    end
    check("done_timeout", done, 1);
    @(negedge prog_clk);
  endtask

  task automatic check_load(input logic [7:0] w1, input bit exp_err, input bit contiguous);
    logic [39:0] stream;
    logic [CHAIN_LEN-1:0] exp_chain;
    stream    = {8'hA5, w1, 8'hFF, 8'h00, 8'h80};
    exp_chain = stream[39:7];
    check("en_count", en_count, NP * CHAIN_LEN);
    if (contiguous) check("en_contiguous", p1_last - first_en + 1, CHAIN_LEN);
    check("done_latency", done_cyc, last_en + 1);
    check("chain_contents", chain, exp_chain);
    check("tail_bit", ccff_tail, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("ready_after", cfg_ready, 0);
    check("error_after", error, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int saved;
    prog_reset = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    clear_stats();
    repeat (3) tick();
    check("rst_head", ccff_head, 0);
    check("rst_en", chain_clk_en, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    prog_reset = 1'b0;
    tick();

    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", cfg_ready, 1);
    check("start_done", done, 0);

    // Back-to-back full load
    for (int p = 0; p < NP; p++) do_pass(8'h3C, 0, 1'b0);
    wait_done();
    check_load(8'h3C, 1'b0, 1'b1);

    // cfg_valid held in DONE must be ignored
    saved     = en_count;
    cfg_data  = 8'h55;
    cfg_valid = 1'b1;
    repeat (10) tick();
    check("done_hold_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    repeat (2) tick();
    check("done_hold_en", en_count, saved);
    check("done_hold_done", done, 1);
    check("done_hold_busy", busy, 0);

    // Starvation gap plus a start pulse while busy
    pulse_start();
    do_pass(8'h3C, 20, 1'b1);
    for (int p = 1; p < NP; p++) do_pass(8'h3C, 0, 1'b0);
    wait_done();
    check_load(8'h3C, 1'b0, 1'b0);
    check("starve_gap", (p1_last - first_en + 1) > CHAIN_LEN, 1);

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    pulse_start();
    do_pass(8'h3C, 0, 1'b0);
    do_pass(8'h3D, 0, 1'b0);
    wait_done();
    check_load(8'h3D, 1'b1, 1'b1);
    repeat (5) tick();
    check("error_sticky", error, 1);
`endif

    // Mid-load reset after 12 shifted bits
    pulse_start();
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    cfg_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      #1;
      if (en_count == 12) break;
    end
    check("mid_bits", en_count, 12);
    prog_reset = 1'b1;
    tick();
    check("mid_rst_head", ccff_head, 0);
    check("mid_rst_en", chain_clk_en, 0);
    check("mid_rst_ready", cfg_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    prog_reset = 1'b0;
    exp_q.delete();
    tick();
    pulse_start();
    for (int p = 0; p < NP; p++) do_pass(8'h3C, 0, 1'b0);
    wait_done();
    check_load(8'h3C, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
